bank_conflict_resolver_n: RTL
=============================

Name: bank_conflict_resolver_n

Overview:
Parametrised successor to the 8-lane bank conflict resolver in the edge-processing pipeline. Accepts a bundle of LANES edges per handshake and issues each edge exactly once. Per issue cycle, at most one edge per bank is issued, and the lowest lane index wins a bank. Adds a ready/valid input handshake, a per-lane enable mask for partial bundles, and a configurable bank-field position.

Parameters:
LANES, 8, lanes per bundle (2..32)
EDGE_W, 96, bits per edge
BANK_W, 5, width of bank-select field
BANK_LSB, 0, bit offset of bank field within each edge (BANK_LSB+BANK_W <= EDGE_W)
CNT_W, 32, width of statistics counter (STATS_EN only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  bundle offered
in_ready  out  1  bundle accepted when in_valid & in_ready
in_data  in  LANES*EDGE_W  lane i at bits [i*EDGE_W +: EDGE_W]
in_mask  in  LANES  1 = lane carries an edge; 0 = lane empty
stall  in  1  downstream back-pressure; freezes issue
out_data  out  LANES*EDGE_W  registered copy of held bundle, same lane layout
out_valid  out  LANES  per-lane issue strobe, one cycle
out_last  out  1  pulses with final issue cycle of a bundle
stat_extra_cycles  out  CNT_W  issue cycles beyond the first per bundle (STATS_EN only)

Behaviour:
- Reset (rst_n low, async): hold_valid=0, done mask=0, out_data=0, out_valid=0, out_last=0, stat_extra_cycles=0. in_ready is combinational: it reads 1 while hold is empty. A reset mid-bundle discards the bundle; no partial re-issue follows.
- Hold stage: hold_data, hold_mask, hold_valid and done[LANES]. On acceptance, load the bundle and set done = ~in_mask.
- bank(i) = hold_data[i*EDGE_W+BANK_LSB +: BANK_W].
- pending[i] = hold_valid & ~done[i].
- grant[i] = pending[i] & no j<i with grant[j] & bank(j)==bank(i). This is a fixed lowest-index priority chain.
- final = hold_valid & ((done|grant) == all ones).
- in_ready = ~hold_valid | (final & ~stall). Throughput is one bundle per cycle when conflict-free.
- Per cycle with stall=0:
  - out_valid <= grant
  - out_last <= final
  - done <= final ? (accept ? ~in_mask : 0) : done|grant
  - hold_valid <= final ? accept : hold_valid
- Per cycle with stall=1: out_valid <= 0, out_last <= 0. Hold, done and in_ready=0 (if hold_valid) are frozen, with no grants. This also applies to an empty hold.
- out_data <= hold_data every cycle regardless of stall. It is meaningful only in lanes where out_valid=1.
- Latency: a bundle accepted at edge k gives its first out_valid at edge k+1. A bundle with B edges in the most-loaded bank takes exactly B unstalled issue cycles.
- Mask all-zero bundle: accepted; final on the first unstalled cycle; out_last=1 with out_valid=0.
- hold_valid=0: no grants and out_last=0.
- Simultaneous final and in_valid: the new bundle loads on the same edge with no bubble.
- in_data and in_mask are sampled only on acceptance. Changes while in_ready=0 are ignored.

Optional Feature:
Macro CONFLICT_STATS_EN.
- Defined: stat_extra_cycles increments by 1 on each unstalled cycle where hold_valid & ~final. It saturates at all ones and clears only on reset.
- Undefined: the port is present and tied to 0, and no counter logic is built.

Test Plan:
1. LANES=8. Banks of lanes 0..7 = 0..7, mask 0xFF. -> One cycle: out_valid=0xFF, out_last=1, in_ready stays 1. Back-to-back bundles run at 1/cycle.
2. All lanes bank 3, mask 0xFF. -> out_valid 0x01,0x02,…,0x80 on 8 consecutive cycles. out_last on the 8th. in_ready=0 for the first 7 cycles. Stats counter +7.
3. Banks {0,1,0,2,1,3,0,4} for lanes 0..7. -> out_valid 0xAB, then 0x14, then 0x40 (out_last=1). Stats counter +2.
4. Scenario 3 with stall=1 for 2 cycles after the 0xAB issue. -> out_valid=0 and out_last=0 during the stall. Then 0x14, 0x40 resume. No lane is issued twice or dropped.
5. Mask 0x0F, all lanes bank 7. -> 0x01,0x02,0x04,0x08, with out_last on 0x08. Mask 0x00 -> single cycle, out_valid=0, out_last=1.
6. Drop rst_n asynchronously midway through scenario 2. -> out_valid, out_last and stats go to 0 immediately; in_ready=1. After release, a new bundle issues correctly with no leftover lanes.

Source files
------------

// File: rtl/bank_conflict_resolver_n_if.sv
// Bundle handshake and issue bus of bank_conflict_resolver_n.
//   in_valid/in_ready : bundle handshake, transfer when both high
//   in_data/in_mask   : LANES edges of EDGE_W bits, lane i at [i*EDGE_W +: EDGE_W]
//   stall             : downstream back-pressure, freezes issue
//   out_data          : registered copy of the held bundle
//   out_valid/out_last: per-lane issue strobes, final-cycle marker
// Modport slave is the resolver side, master the producer/consumer side.
interface bank_conflict_resolver_n_if #(
   parameter int LANES  = 8,
   parameter int EDGE_W = 96
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*EDGE_W-1:0]   in_data;
   logic [LANES-1:0]          in_mask;
   logic                      stall;
   logic [LANES*EDGE_W-1:0]   out_data;
   logic [LANES-1:0]          out_valid;
   logic                      out_last;

   modport slave (
      input  in_valid, in_data, in_mask, stall,
      output in_ready, out_data, out_valid, out_last
   );

   modport master (
      output in_valid, in_data, in_mask, stall,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/bank_conflict_resolver_n.sv
// Bank conflict resolver: holds one bundle of LANES edges and issues each
// edge exactly once, at most one edge per bank per issue cycle, lowest lane
// wins a bank.
//   clk, rst_n         : clock (rising), asynchronous active-low reset
//   bus (slave)        : bundle handshake, stall, issue outputs
//   stat_extra_cycles  : issue cycles beyond the first per bundle
// Optional macro CONFLICT_STATS_EN builds the saturating statistics counter;
// without it stat_extra_cycles is tied to zero.

// Per-lane grant. A lane is blocked when any lower pending lane targets the
// same bank: if that lower lane is itself blocked, its blocker also shares
// the bank, so this matches the lowest-index priority chain without a
// ripple through neighbouring grants.
module bank_conflict_resolver_n_lane #(
   parameter int LANES  = 8,
   parameter int BANK_W = 5,
   parameter int IDX    = 0
) (
   input  logic [LANES-1:0]             pending,
   input  logic [LANES-1:0][BANK_W-1:0] banks,
   output logic                         grant
);
   localparam logic [LANES-1:0] LOWER = (LANES'(1) << IDX) - LANES'(1);

   logic [LANES-1:0] same;

   always_comb begin
      same = '0;
      for (int j = 0; j < LANES; j++) same[j] = (banks[j] == banks[IDX]);
   end

   assign grant = pending[IDX] & ~|(pending & same & LOWER);
endmodule

module bank_conflict_resolver_n #(
   parameter int LANES    = 8,
   parameter int EDGE_W   = 96,
   parameter int BANK_W   = 5,
   parameter int BANK_LSB = 0,
   parameter int CNT_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   bank_conflict_resolver_n_if.slave     bus,
   output logic [CNT_W-1:0]              stat_extra_cycles
);
   logic [LANES*EDGE_W-1:0]      hold_data;
   logic                         hold_valid;
   // done starts as ~mask, so empty lanes need no separate mask register
   logic [LANES-1:0]             done;
   logic [LANES-1:0]             pending;
   logic [LANES-1:0]             grant;
   logic [LANES-1:0][BANK_W-1:0] banks;
   logic                         fin;
   logic                         accept;

   assign pending = {LANES{hold_valid}} & ~done;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign banks[i] = hold_data[i*EDGE_W+BANK_LSB +: BANK_W];

      bank_conflict_resolver_n_lane #(
         .LANES  (LANES),
         .BANK_W (BANK_W),
         .IDX    (i)
      ) u_lane (
         .pending (pending),
         .banks   (banks),
         .grant   (grant[i])
      );
   end

   assign fin          = hold_valid & (&(done | grant));
   assign bus.in_ready = ~hold_valid | (fin & ~bus.stall);
   assign accept       = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid    <= 1'b0;
         hold_data     <= '0;
         done          <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= '0;
         bus.out_last  <= 1'b0;
      end else begin
         bus.out_data  <= hold_data;
         bus.out_valid <= bus.stall ? '0 : grant;
         bus.out_last  <= ~bus.stall & fin;
         // accept can fire under stall only while the hold is empty
         if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= bus.in_data;
            done       <= ~bus.in_mask;
         end else if (!bus.stall && fin) begin
            hold_valid <= 1'b0;
            done       <= '0;
         end else if (!bus.stall) begin
            done       <= done | grant;
         end
      end
   end

`ifdef CONFLICT_STATS_EN
   logic [CNT_W-1:0] extra_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         extra_cnt <= '0;
      else if (!bus.stall && hold_valid && !fin && !(&extra_cnt))
         extra_cnt <= extra_cnt + CNT_W'(1);
   end

   assign stat_extra_cycles = extra_cnt;
`else
   assign stat_extra_cycles = '0;
`endif
endmodule
